fetch_redirect_ctrl: RTL and testbench
======================================

// Module: fetch_redirect_ctrl
// PURPOSE
//   Consumer of the branch decision: owns the program counter and drives the instruction-memory fetch handshake.
//   Applies the redirect from the branch-decision flag (b_out) or an unconditional jump.
//   Drops any stale in-flight fetch and presents one instruction at a time to decode through a stall-able buffer.
//   Sits between the branch/ALU stage and the instruction-memory port.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC loaded on reset; first fetch address
//   XLEN      32             address/instruction width
// PORTS
//   clk            in   1     system clock, rising edge
//   nrst           in   1     asynchronous active-low reset
//   b_out          in   1     conditional branch taken (already qualified by branch type)
//   branch_target  in   XLEN  target for b_out
//   jump           in   1     unconditional jump (JAL/JALR)
//   jump_target    in   XLEN  target for jump
//   stall          in   1     decode cannot accept; holds the instruction buffer
//   imem_ack       in   1     instruction memory has completed the current request
//   imem_rdata     in   XLEN  fetched word, valid with imem_ack
//   imem_req       out  1     fetch request, held high until imem_ack
//   imem_addr      out  XLEN  fetch address, stable while imem_req=1
//   instr_valid    out  1     instr/instr_pc hold a live instruction
//   instr          out  XLEN  buffered instruction
//   instr_pc       out  XLEN  PC of the buffered instruction
//   flush          out  1     one-cycle pulse, registered, the cycle after a redirect
//   misalign_err   out  1     one-cycle pulse, registered: redirect target[1:0] != 0
// BEHAVIOUR
//   Reset (async, nrst=0)
//     - pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, instr_valid=0.
//     - instr=32'h0000_0013 (NOP), instr_pc=0, flush=0, misalign_err=0.
//     - Reset mid-transaction abandons the fetch; a late imem_ack while state=IDLE is ignored.
//   redirect = jump | b_out; tgt = jump ? jump_target : branch_target (jump wins); tgt[1:0] forced to 0.
//   consume = instr_valid & ~stall: instr_valid clears next edge unless a new load occurs that edge.
//   imem_req = (state==REQ) | (state==DISCARD), Moore output; imem_addr is a register.
//   FSM, no redirect:
//     IDLE   : if ~instr_valid | consume -> REQ, imem_addr<=pc; else stay.
//     REQ    : on imem_ack -> load instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, pc<=pc+4; -> IDLE.
//              Without imem_ack, stay; addr held.
//     DISCARD: on imem_ack -> drop data, -> REQ, imem_addr<=pc; else stay.
//   FSM, redirect (overrides all same-cycle actions; instr_valid<=0, pc<=tgt, flush<=1 next cycle):
//     IDLE -> REQ, imem_addr<=tgt.
//     REQ, no ack -> DISCARD; outstanding request stays high at the old address (never withdrawn).
//     REQ with ack -> response dropped, -> REQ, imem_addr<=tgt.
//     DISCARD, no ack -> stay; pc takes the newest tgt.
//     DISCARD with ack -> REQ, imem_addr<=tgt.
//   Arithmetic and timing
//     - pc+4 is modulo 2^XLEN: 32'hFFFF_FFFC -> 32'h0.
//     - Throughput is one instruction per 2 cycles minimum (REQ->IDLE->REQ).
//     - Fetch latency: 1 cycle req-to-ack minimum; instr_valid rises the edge after imem_ack.
//   Misalignment: misalign_err<=1 for one cycle on a redirect with tgt[1:0]!=0; the redirect still proceeds.
// TESTING
//   1. Reset release, imem_ack 1 cycle after each req, stall=0:
//      -> addrs 0,4,8,...; instr_valid every 2nd cycle; instr_pc matches.
//   2. stall=1 for 5 cycles while instr_valid=1:
//      -> instr/instr_pc held, imem_req=0, pc unchanged; fetch resumes the cycle stall drops.
//   3. b_out=1, branch_target=0x100 while REQ outstanding at 0x8, ack 3 cycles later:
//      -> flush pulse; req stays at 0x8; data dropped; next req at 0x100.
//   4. jump=1 (target 0x40) and b_out=1 (target 0x80) same cycle -> next fetch 0x40.
//   5. RESET_PC=32'hFFFF_FFFC, one fetch -> next imem_addr=32'h0.
//      Redirect to 0x102 -> misalign_err pulse, fetch 0x100.
//   6. nrst low mid-REQ, then ack arrives -> outputs at reset values, no load; first fetch after release at RESET_PC.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// Fetch/redirect controller: owns the PC, runs the instruction-memory request handshake,
// squashes stale in-flight fetches on branch/jump and buffers one instruction for decode.
module fetch_redirect_ctrl #(
   parameter int unsigned        XLEN     = 32,
   parameter logic [XLEN-1:0]    RESET_PC = '0
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            b_out,
   input  logic [XLEN-1:0] branch_target,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_target,
   input  logic            stall,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic            flush,
   output logic            misalign_err
);

   localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [XLEN-1:0] pc, pc_n;
   logic [XLEN-1:0] addr_n;
   logic            valid_n;
   logic [XLEN-1:0] instr_n, instr_pc_n;
   logic            redirect, consume;
   logic [XLEN-1:0] tgt_raw, tgt;

   assign redirect = jump | b_out;
   assign tgt_raw  = jump ? jump_target : branch_target;
   assign tgt      = {tgt_raw[XLEN-1:2], 2'b00};
   assign consume  = instr_valid & ~stall;
   assign imem_req = (state == REQ) || (state == DISCARD);

   // NOTE: every signal assigned in this block gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      addr_n     = imem_addr;
      valid_n    = consume ? 1'b0 : instr_valid;
      instr_n    = instr;
      instr_pc_n = instr_pc;

      if (redirect) begin
         // A request already on the bus is never withdrawn; DISCARD waits out its ack.
         valid_n = 1'b0;
         pc_n    = tgt;
         unique case (state)
            IDLE: begin
               state_n = REQ;
               addr_n  = tgt;
            end
            REQ: begin
               if (imem_ack) begin
                  state_n = REQ;
                  addr_n  = tgt;
               end else begin
                  state_n = DISCARD;
               end
            end
            DISCARD: begin
               if (imem_ack) begin
                  state_n = REQ;
                  addr_n  = tgt;
               end
            end
            default: state_n = IDLE;
         endcase
      end else begin
         unique case (state)
            IDLE: begin
               if (!instr_valid || consume) begin
                  state_n = REQ;
                  addr_n  = pc;
               end
            end
            REQ: begin
               if (imem_ack) begin
                  state_n    = IDLE;
                  instr_n    = imem_rdata;
                  instr_pc_n = imem_addr;
                  valid_n    = 1'b1;
                  pc_n       = pc + XLEN'(4);
               end
            end
            DISCARD: begin
               if (imem_ack) begin
                  state_n = REQ;
                  addr_n  = pc;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         imem_addr    <= RESET_PC;
         instr_valid  <= 1'b0;
         instr        <= NOP;
         instr_pc     <= '0;
         flush        <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_n;
         pc           <= pc_n;
         imem_addr    <= addr_n;
         instr_valid  <= valid_n;
         instr        <= instr_n;
         instr_pc     <= instr_pc_n;
         flush        <= redirect;
         misalign_err <= redirect && (tgt_raw[1:0] != 2'b00);
      end
   end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: sequential fetch, stall, branch squash, jump priority,
// PC wrap, misaligned redirect and reset mid-request. Inputs change and outputs are sampled on negedge.
module tb_fetch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        nrst;
   logic        b_out, jump, stall, imem_ack;
   logic [31:0] branch_target, jump_target, imem_rdata;

   logic        req0, valid0, flush0, mis0;
   logic [31:0] addr0, instr0, ipc0;
   logic        req1, valid1, flush1, mis1;
   logic [31:0] addr1, instr1, ipc1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_redirect_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut0 (
      .clk(clk), .nrst(nrst), .b_out(b_out), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .stall(stall),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .imem_req(req0), .imem_addr(addr0), .instr_valid(valid0),
      .instr(instr0), .instr_pc(ipc0), .flush(flush0), .misalign_err(mis0)
   );

   fetch_redirect_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_dut1 (
      .clk(clk), .nrst(nrst), .b_out(b_out), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .stall(stall),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .imem_req(req1), .imem_addr(addr1), .instr_valid(valid1),
      .instr(instr1), .instr_pc(ipc1), .flush(flush1), .misalign_err(mis1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] dat(input logic [31:0] a);
      return a ^ 32'h5A00_0000;
   endfunction

   initial begin
      nrst = 1'b0; b_out = 1'b0; jump = 1'b0; stall = 1'b0; imem_ack = 1'b0;
      branch_target = '0; jump_target = '0; imem_rdata = '0;
      tick(); tick();

      check("rst_req",   32'(req0),   32'd0);
      check("rst_addr",  addr0,       32'h0);
      check("rst_valid", 32'(valid0), 32'd0);
      check("rst_instr", instr0,      32'h0000_0013);
      check("rst_ipc",   ipc0,        32'h0);
      check("rst_flush", 32'(flush0), 32'd0);
      check("rst_mis",   32'(mis0),   32'd0);
      check("rst_addr1", addr1,       32'hFFFF_FFFC);

      // 1: back-to-back sequential fetches, ack in the first request cycle
      nrst = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("seq_req",   32'(req0),   32'd1);
         check("seq_addr",  addr0,       32'(4 * i));
         check("seq_vlo",   32'(valid0), 32'd0);
         imem_ack = 1'b1; imem_rdata = dat(32'(4 * i));
         tick();
         imem_ack = 1'b0;
         check("seq_vhi",   32'(valid0), 32'd1);
         check("seq_instr", instr0,      dat(32'(4 * i)));
         check("seq_ipc",   ipc0,        32'(4 * i));
         check("seq_reqlo", 32'(req0),   32'd0);
         tick();
      end

      // 2: stall holds the buffer and blocks the next fetch
      imem_ack = 1'b1; imem_rdata = dat(32'hC);
      tick();
      imem_ack = 1'b0; stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stl_valid", 32'(valid0), 32'd1);
         check("stl_instr", instr0,      dat(32'hC));
         check("stl_ipc",   ipc0,        32'hC);
         check("stl_req",   32'(req0),   32'd0);
      end
      stall = 1'b0;
      tick();
      check("stl_resume_req",  32'(req0), 32'd1);
      check("stl_resume_addr", addr0,     32'h10);
      check("stl_resume_v",    32'(valid0), 32'd0);

      // 3: branch while a request is outstanding; old request held, its data dropped
      b_out = 1'b1; branch_target = 32'h100;
      tick();
      b_out = 1'b0;
      check("br_flush", 32'(flush0), 32'd1);
      check("br_req",   32'(req0),   32'd1);
      check("br_hold",  addr0,       32'h10);
      tick();
      check("br_flush_lo", 32'(flush0), 32'd0);
      check("br_hold2",    addr0,       32'h10);
      tick();
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      check("br_drop_v",  32'(valid0), 32'd0);
      check("br_newaddr", addr0,       32'h100);
      check("br_newreq",  32'(req0),   32'd1);
      imem_rdata = dat(32'h100);
      tick();
      imem_ack = 1'b0;
      check("br_load_v",   32'(valid0), 32'd1);
      check("br_load_i",   instr0,      dat(32'h100));
      check("br_load_ipc", ipc0,        32'h100);
      tick();
      check("br_next", addr0, 32'h104);

      // 4: jump and branch in the same cycle; jump wins
      jump = 1'b1; jump_target = 32'h40; b_out = 1'b1; branch_target = 32'h80;
      tick();
      jump = 1'b0; b_out = 1'b0;
      check("jmp_flush", 32'(flush0), 32'd1);
      imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
      tick();
      check("jmp_addr", addr0, 32'h40);
      imem_rdata = dat(32'h40);
      tick();
      imem_ack = 1'b0;
      check("jmp_ipc", ipc0, 32'h40);
      tick();
      check("jmp_next", addr0, 32'h44);

      // redirect coinciding with ack in REQ: response dropped, straight to target
      b_out = 1'b1; branch_target = 32'h200; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
      tick();
      b_out = 1'b0; imem_ack = 1'b0;
      check("rak_v",    32'(valid0), 32'd0);
      check("rak_addr", addr0,       32'h200);
      check("rak_req",  32'(req0),   32'd1);

      // 6: reset in the middle of a request, ack arrives late
      nrst = 1'b0;
      #1;
      check("mrst_req",   32'(req0),   32'd0);
      check("mrst_addr",  addr0,       32'h0);
      check("mrst_valid", 32'(valid0), 32'd0);
      check("mrst_instr", instr0,      32'h0000_0013);
      check("mrst_flush", 32'(flush0), 32'd0);
      imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
      tick();
      check("mrst_noload", 32'(valid0), 32'd0);
      nrst = 1'b1;
      tick();
      check("mrst_late_v",   32'(valid0), 32'd0);
      check("mrst_late_i",   instr0,      32'h0000_0013);
      check("mrst_first",    addr0,       32'h0);
      check("mrst_first_rq", 32'(req0),   32'd1);

      // 5: PC wrap on the second instance, then misaligned redirect
      check("wrap_addr0", addr1, 32'hFFFF_FFFC);
      imem_rdata = dat(32'hFFFF_FFFC);
      tick();
      imem_ack = 1'b0;
      check("wrap_ipc", ipc1, 32'hFFFF_FFFC);
      tick();
      check("wrap_next", addr1, 32'h0);
      b_out = 1'b1; branch_target = 32'h102;
      tick();
      b_out = 1'b0;
      check("mis_pulse1", 32'(mis1),   32'd1);
      check("mis_pulse0", 32'(mis0),   32'd1);
      check("mis_flush",  32'(flush1), 32'd1);
      tick();
      check("mis_lo", 32'(mis1), 32'd0);
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      check("mis_addr", addr1, 32'h100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
